// File: rtl/data_memory_pipelined.sv
// Big-endian byte-addressable data memory for the MEM stage: sized/aligned loads and stores,
// sequential post-reset clear, fixed-latency in-order response pipeline.
module data_memory_pipelined #(
   parameter int DATA_WIDTH   = 32,
   parameter int MEM_SIZE     = 4096,
   parameter int ADDR_WIDTH   = $clog2(MEM_SIZE),
   parameter int READ_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err
);
   localparam int BYTES = DATA_WIDTH / 8;
   localparam int WORDS = MEM_SIZE / BYTES;
   localparam int OFFW  = $clog2(BYTES);
   localparam int CW    = $clog2(WORDS);

   typedef enum logic {CLEAR, READY} state_t;
   state_t state, state_nxt;

   logic [CW-1:0]         clr_cnt;
   logic [DATA_WIDTH-1:0] mem [WORDS];

   logic [OFFW-1:0]       off;
   logic [CW-1:0]         idx;
   logic                  acc, err;
   int                    nb, nbs, sh;
   logic [BYTES-1:0]      wmask;
   logic [DATA_WIDTH-1:0] wword, shifted, ld, rsp_d;
   logic                  fill;

   logic [READ_LATENCY:1] vld_pipe, err_pipe;
   logic [DATA_WIDTH-1:0] dat_pipe [1:READ_LATENCY];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= CLEAR;
         clr_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      if (state == CLEAR && clr_cnt == CW'(WORDS - 1)) state_nxt = READY;
   end

   assign req_ready = (state == READY);
   assign acc       = req_valid & req_ready;
   assign off       = req_addr[OFFW-1:0];
   assign idx       = req_addr[ADDR_WIDTH-1:OFFW];

   // Byte offset b lives in bits [DATA_WIDTH-1-8b -: 8]; sh right-aligns the accessed bytes.
   always_comb begin
      nb  = 1 << req_size;
      err = ((BYTES == 4) && (req_size == 2'b11)) || ((int'(off) % nb) != 0);
      nbs = err ? 1 : nb;
      sh  = err ? 0 : (BYTES - int'(off) - nb) * 8;
      wword = req_wdata << sh;
      for (int b = 0; b < BYTES; b++)
         wmask[b] = !err && (b >= int'(off)) && (b < int'(off) + nb);
      shifted = mem[idx] >> sh;
      fill    = !req_unsigned && shifted[nbs*8-1];
      for (int i = 0; i < BYTES; i++)
         ld[i*8 +: 8] = (i < nbs) ? shifted[i*8 +: 8] : {8{fill}};
      rsp_d = (req_we || err) ? '0 : ld;
   end

   always_ff @(posedge clk) begin
      if (state == CLEAR)
         mem[clr_cnt] <= '0;
      else if (acc && req_we)
         for (int b = 0; b < BYTES; b++)
            if (wmask[b]) mem[idx][DATA_WIDTH-1-8*b -: 8] <= wword[DATA_WIDTH-1-8*b -: 8];
   end

   // Idle stages carry zero data so the outputs read 0 whenever rsp_valid is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe <= '0;
         err_pipe <= '0;
         for (int s = 1; s <= READ_LATENCY; s++) dat_pipe[s] <= '0;
      end else begin
         vld_pipe[1] <= acc;
         err_pipe[1] <= acc & err;
         dat_pipe[1] <= acc ? rsp_d : '0;
         for (int s = 2; s <= READ_LATENCY; s++) begin
            vld_pipe[s] <= vld_pipe[s-1];
            err_pipe[s] <= err_pipe[s-1];
            dat_pipe[s] <= dat_pipe[s-1];
         end
      end
   end

   assign rsp_valid = vld_pipe[READ_LATENCY];
   assign rsp_err   = err_pipe[READ_LATENCY];
   assign rsp_rdata = dat_pipe[READ_LATENCY];
endmodule

// File: tb/tb_data_memory_pipelined.sv
// Bench for data_memory_pipelined (32-bit, 4 KiB, latency 2): directed scenarios plus
// randomized traffic against a byte-array reference model.
module tb_data_memory_pipelined;
   logic        clk = 0, rst = 1;
   logic        req_valid = 0, req_ready, req_we = 0, req_unsigned = 0;
   logic [1:0]  req_size = 0;
   logic [11:0] req_addr = 0;
   logic [31:0] req_wdata = 0;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;

   typedef struct {logic [31:0] d; logic e; int c;} rsp_t;
   rsp_t rsp_q[$];
   logic [7:0] mref [4096];
   int cyc = 0, n_cmp = 0, n_bad = 0;

   data_memory_pipelined dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (rsp_valid) rsp_q.push_back('{rsp_rdata, rsp_err, cyc});

   function automatic void model_clear();
      for (int i = 0; i < 4096; i++) mref[i] = 8'h00;
   endfunction

   // Big-endian: lowest address holds the most significant byte of the access.
   function automatic void model_ref(input logic we, input logic [1:0] sz, input logic uns,
                                     input logic [11:0] a, input logic [31:0] wd,
                                     output logic [31:0] d, output logic e);
      int nb = 1 << sz;
      logic [63:0] v;
      e = (sz == 2'd3) || ((int'(a) % nb) != 0);
      d = 32'h0;
      if (e) return;
      if (we) begin
         for (int i = 0; i < nb; i++) mref[int'(a) + i] = 8'(wd >> (8 * (nb - 1 - i)));
      end else begin
         v = 64'h0;
         for (int i = 0; i < nb; i++) v = (v << 8) | 64'(mref[int'(a) + i]);
         if (!uns && v[8*nb-1]) v = v | (~64'h0 << (8 * nb));
         d = v[31:0];
      end
   endfunction

   task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [11:0] a, input logic [31:0] wd);
      req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = a; req_wdata = wd;
   endtask

   // Single isolated request; returns the response and edges from accept to response.
   task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [11:0] a, input logic [31:0] wd,
                       output logic [31:0] d, output logic e, output int dc);
      int k;
      logic [31:0] md;
      logic me;
      rsp_q.delete();
      drive(we, sz, uns, a, wd);
      @(posedge clk); #1;
      k = cyc;
      model_ref(we, sz, uns, a, wd, md, me);
      req_valid = 0;
      repeat (5) @(posedge clk);
      #1;
      if (rsp_q.size() == 1) begin
         d = rsp_q[0].d; e = rsp_q[0].e; dc = rsp_q[0].c - k;
      end else begin
         d = 'x; e = 'x; dc = -1;
      end
   endtask

   task automatic wait_clear(output int edge_n);
      edge_n = -1;
      for (int i = 1; i <= 1100; i++) begin
         @(posedge clk); #1;
         if (req_ready) begin edge_n = i; break; end
      end
   endtask

   task automatic test_reset;
      int edge_n, dc;
      logic [31:0] d;
      logic e;
      rst = 1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", req_ready); end
      n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
      n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
      n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", rsp_err); end
      rst = 0;
      model_clear();
      wait_clear(edge_n);
      n_cmp++; if (edge_n !== 1024) begin n_bad++; $display("FAIL clear_edges: got %0d want 1024", edge_n); end
      xact(0, 2, 0, 12'h000, 0, d, e, dc);
      n_cmp++; if (d !== 32'h0 || e !== 1'b0) begin n_bad++; $display("FAIL clear_lw0: got %h/%b want 00000000/0", d, e); end
      n_cmp++; if (dc !== 1) begin n_bad++; $display("FAIL clear_lat: got %0d want 1", dc); end
   endtask

   task automatic test_load_store;
      logic [31:0] d;
      logic e;
      int dc;
      logic [11:0] addrs [5] = '{12'h010, 12'h010, 12'h013, 12'h012, 12'h010};
      logic [1:0]  sizes [5] = '{2'd2, 2'd0, 2'd0, 2'd1, 2'd1};
      logic        unss  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [31:0] wants [5] = '{32'hDEADBEEF, 32'hFFFFFFDE, 32'h000000EF, 32'hFFFFBEEF, 32'h0000DEAD};
      xact(1, 2, 0, 12'h010, 32'hDEADBEEF, d, e, dc);
      n_cmp++; if (d !== 32'h0 || e !== 1'b0 || dc !== 1) begin n_bad++; $display("FAIL sw_rsp: got %h/%b/%0d want 00000000/0/1", d, e, dc); end
      for (int i = 0; i < 5; i++) begin
         xact(0, sizes[i], unss[i], addrs[i], 0, d, e, dc);
         n_cmp++; if (d !== wants[i] || e !== 1'b0) begin n_bad++; $display("FAIL load_%0d: got %h/%b want %h/0", i, d, e, wants[i]); end
      end
   endtask

   task automatic test_lane_mask;
      logic [31:0] d;
      logic e;
      int dc;
      xact(1, 0, 0, 12'h011, 32'hAAAAAA11, d, e, dc);
      xact(0, 2, 0, 12'h010, 0, d, e, dc);
      n_cmp++; if (d !== 32'hDE11BEEF) begin n_bad++; $display("FAIL lane_mask: got %h want DE11BEEF", d); end
   endtask

   task automatic test_misalign;
      logic [31:0] d;
      logic e;
      int dc;
      xact(0, 2, 0, 12'h012, 0, d, e, dc);
      n_cmp++; if (d !== 32'h0 || e !== 1'b1) begin n_bad++; $display("FAIL mis_lw: got %h/%b want 00000000/1", d, e); end
      xact(1, 1, 0, 12'h011, 32'h5555, d, e, dc);
      n_cmp++; if (d !== 32'h0 || e !== 1'b1) begin n_bad++; $display("FAIL mis_sh: got %h/%b want 00000000/1", d, e); end
      xact(0, 3, 0, 12'h010, 0, d, e, dc);
      n_cmp++; if (d !== 32'h0 || e !== 1'b1) begin n_bad++; $display("FAIL ill_ld: got %h/%b want 00000000/1", d, e); end
      xact(1, 3, 0, 12'h010, 32'h0, d, e, dc);
      xact(0, 2, 0, 12'h010, 0, d, e, dc);
      n_cmp++; if (d !== 32'hDE11BEEF || e !== 1'b0) begin n_bad++; $display("FAIL mis_nowrite: got %h/%b want DE11BEEF/0", d, e); end
   endtask

   task automatic test_back_to_back;
      int k;
      logic [31:0] md;
      logic me;
      rsp_q.delete();
      drive(1, 2, 0, 12'h020, 32'h12345678);
      @(posedge clk); #1;
      k = cyc;
      model_ref(1, 2, 0, 12'h020, 32'h12345678, md, me);
      drive(0, 2, 0, 12'h020, 0);
      @(posedge clk); #1;
      model_ref(0, 2, 0, 12'h020, 0, md, me);
      req_valid = 0;
      repeat (4) @(posedge clk);
      #1;
      n_cmp++;
      if (rsp_q.size() != 2) begin
         n_bad++; $display("FAIL b2b_count: got %0d want 2", rsp_q.size());
      end else begin
         if (rsp_q[0].c !== k + 1 || rsp_q[1].c !== k + 2) begin
            n_bad++; $display("FAIL b2b_timing: got %0d,%0d want %0d,%0d", rsp_q[0].c, rsp_q[1].c, k + 1, k + 2);
         end
         n_cmp++; if (rsp_q[0].d !== 32'h0 || rsp_q[0].e !== 1'b0) begin n_bad++; $display("FAIL b2b_sw: got %h/%b want 00000000/0", rsp_q[0].d, rsp_q[0].e); end
         n_cmp++; if (rsp_q[1].d !== 32'h12345678) begin n_bad++; $display("FAIL b2b_lw: got %h want 12345678", rsp_q[1].d); end
      end
   endtask

   task automatic test_random;
      rsp_t eq[$];
      logic [31:0] md;
      logic me;
      int n;
      rsp_q.delete();
      for (int i = 0; i < 400; i++) begin
         req_valid    = ($urandom_range(0, 3) != 0);
         req_we       = 1'($urandom_range(0, 1));
         req_size     = 2'($urandom_range(0, 3));
         req_unsigned = 1'($urandom_range(0, 1));
         req_addr     = 12'h100 + 12'($urandom_range(0, 63));
         req_wdata    = $urandom;
         @(posedge clk); #1;
         if (req_valid) begin
            model_ref(req_we, req_size, req_unsigned, req_addr, req_wdata, md, me);
            eq.push_back('{md, me, cyc + 1});
         end
      end
      req_valid = 0;
      repeat (4) @(posedge clk);
      #1;
      n_cmp++; if (rsp_q.size() != eq.size()) begin n_bad++; $display("FAIL rand_count: got %0d want %0d", rsp_q.size(), eq.size()); end
      n = (rsp_q.size() < eq.size()) ? rsp_q.size() : eq.size();
      for (int i = 0; i < n; i++) begin
         n_cmp++;
         if (rsp_q[i].d !== eq[i].d || rsp_q[i].e !== eq[i].e || rsp_q[i].c !== eq[i].c) begin
            n_bad++;
            $display("FAIL rand_%0d: got %h/%b@%0d want %h/%b@%0d", i, rsp_q[i].d, rsp_q[i].e, rsp_q[i].c, eq[i].d, eq[i].e, eq[i].c);
         end
      end
   endtask

   task automatic test_reset_midflight;
      int edge_n, dc;
      logic [31:0] d;
      logic e;
      drive(0, 2, 0, 12'h020, 0);
      @(posedge clk); #1;
      drive(0, 2, 0, 12'h024, 0);
      @(posedge clk); #1;
      req_valid = 0;
      rsp_q.delete();
      rst = 1;
      #1;
      n_cmp++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL mid_drop: got %b/%h want 0/00000000", rsp_valid, rsp_rdata); end
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      model_clear();
      wait_clear(edge_n);
      n_cmp++; if (edge_n !== 1024) begin n_bad++; $display("FAIL mid_clear_edges: got %0d want 1024", edge_n); end
      n_cmp++; if (rsp_q.size() != 0) begin n_bad++; $display("FAIL mid_ghost: got %0d responses want 0", rsp_q.size()); end
      xact(0, 2, 0, 12'h020, 0, d, e, dc);
      n_cmp++; if (d !== 32'h0 || e !== 1'b0) begin n_bad++; $display("FAIL mid_lw20: got %h/%b want 00000000/0", d, e); end
   endtask

   initial begin
      test_reset();
      test_load_store();
      test_lane_mask();
      test_misalign();
      test_back_to_back();
      test_random();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
